// File: rtl/dest_reg_tracker_if.sv
// Issue/hazard/writeback bundle between decode, the destination tracker
// and the register file write port.
interface dest_reg_tracker_if #(
    parameter int ADDR_W = 5
);
    logic              issue_valid;
    logic [1:0]        rd_select;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] issue_dest;
    logic              hazard_a;
    logic              hazard_b;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic              busy;

    // Decode/control side: presents instructions, consumes hazard and writeback info.
    modport master (
        output issue_valid, rd_select, rt_addr, rd_addr, src_a, src_b, stall, flush,
        input  issue_dest, hazard_a, hazard_b, wb_valid, wb_addr, busy
    );

    // Tracker side.
    modport slave (
        input  issue_valid, rd_select, rt_addr, rd_addr, src_a, src_b, stall, flush,
        output issue_dest, hazard_a, hazard_b, wb_valid, wb_addr, busy
    );
endinterface

// File: rtl/dest_reg_tracker.sv
// Destination register tracker: selects the write destination at issue,
// carries it through a DEPTH-stage writeback pipeline and keeps a
// per-register pending-write count used for RAW hazard detection.
module dest_reg_tracker #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               reset_n,
    dest_reg_tracker_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] destSel;
    logic              wen;
    logic              issueAccept;
    logic              retire;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];

    // Destination mux; the no-write mode still reports rt but never tracks it.
    always_comb begin
        destSel = bus.rt_addr;
        case (bus.rd_select)
            2'd0:    destSel = bus.rt_addr;
            2'd1:    destSel = bus.rd_addr;
            2'd2:    destSel = ADDR_W'(LINK_REG);
            default: destSel = bus.rt_addr;
        endcase
        wen = (bus.rd_select != 2'd3) && (destSel != '0);
    end

    assign issueAccept = bus.issue_valid && !bus.stall && !bus.flush;
    assign retire      = valid_q[DEPTH-1] && !bus.stall && !bus.flush;

    // Next state of the writeback pipeline: flush clears, stall holds, otherwise shift.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (bus.flush) begin
            valid_d = '0;
        end else if (!bus.stall) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                addr_d[i]  = addr_q[i-1];
            end
            valid_d[0] = issueAccept && wen;
            addr_d[0]  = destSel;
        end
    end

    // Next state of the pending-write counters; issue and retire to one register cancel.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 0; r < NREG; r++) begin
            if (bus.flush) begin
                cnt_d[r] = '0;
            end else if ((issueAccept && wen && (destSel == ADDR_W'(r))) &&
                         !(retire && (addr_q[DEPTH-1] == ADDR_W'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (!(issueAccept && wen && (destSel == ADDR_W'(r))) &&
                         (retire && (addr_q[DEPTH-1] == ADDR_W'(r)))) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.issue_dest = destSel;
    assign bus.hazard_a   = (bus.src_a != '0) && (cnt_q[bus.src_a] != '0);
    assign bus.hazard_b   = (bus.src_b != '0) && (cnt_q[bus.src_b] != '0);
    assign bus.wb_valid   = retire;
    assign bus.wb_addr    = addr_q[DEPTH-1];
    assign bus.busy       = |valid_q;
endmodule

// File: doc/dest_reg_tracker.md
# dest_reg_tracker

Parametrised successor to the combinational destination-register mux. It selects the write destination (rt / rd / link / none) at issue, carries it through a DEPTH-stage writeback pipeline, and keeps a per-register pending-write scoreboard. Decode uses the scoreboard to detect RAW hazards on source registers. It sits between control/decode and the register file write port.

## Interface
- ADDR_W, 5, register address width; the register file has 2**ADDR_W entries.
- DEPTH, 3, cycles from issue to writeback; legal range 1..8.
- LINK_REG, 31, destination used when link mode is selected.
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, asynchronous and active-low; clears all state.
- issue_valid  input  1  an instruction is presented for issue this cycle.
- rd_select  input  2  destination mode: 0 = rt, 1 = rd, 2 = LINK_REG, 3 = no write.
- rt_addr  input  ADDR_W  instruction[20:16].
- rd_addr  input  ADDR_W  instruction[15:11].
- src_a, src_b  input  ADDR_W  source registers to check for hazards.
- stall  input  1  freezes the pipeline and blocks issue.
- flush  input  1  squashes all in-flight writes.
- issue_dest  output  ADDR_W  combinational selected destination (rt for the no-write mode).
- hazard_a, hazard_b  output  1  combinational; source has a pending write.
- wb_valid  output  1  the register file write enable.
- wb_addr  output  ADDR_W  register file write address.
- busy  output  1  at least one valid pipeline stage.

## Operation
- Destination selection:
  - wen = (rd_select != 3) && dest != 0. Writes to register 0 are never tracked and never written back.
  - An issue with wen = 0 still occupies a pipeline slot, as a bubble with valid = 0.
- Accepted issue:
  - Issue is accepted when issue_valid && !stall && !flush.
  - Stage 0 captures valid = wen and addr = dest.
  - Each stage shifts to the next on every edge where stall = 0.
- Retire event: the last stage is valid && !stall && !flush. wb_valid = that event; wb_addr = last-stage addr.
- Scoreboard:
  - Each register has a counter of width $clog2(DEPTH+1).
  - An accepted issue with wen increments the counter for dest.
  - A retire event decrements the counter for wb_addr.
  - Issue and retire to the same register in the same cycle leave the count unchanged.
  - A count never exceeds DEPTH, because there are at most DEPTH in-flight entries.
- Hazard outputs: hazard_x = (src_x != 0) && count[src_x] != 0. The lookup is pure combinational from registered counts and does not forward same-cycle issue.
- Flush (synchronous, highest priority):
  - At the next edge, all stage valids and all counters clear.
  - An issue in the same cycle is dropped.
  - wb_valid is held low during the flush cycle.
- Stall: all stages and counters hold, no issue is accepted, and wb_valid is low. The last stage is retired on the first edge after stall deasserts.
- Reset: on reset_n low, asynchronously clear all stage valids, addrs and counters. Outputs after reset: wb_valid = 0, wb_addr = 0, busy = 0, hazard_a = hazard_b = 0.

## Timing
- Issue at edge N (accepted) appears as wb_valid = 1 during the cycle after edge N+DEPTH-1. That gives a latency of DEPTH cycles with no stalls; each stall cycle adds 1.
- hazard_x asserts in the cycle after the accepted issue edge. It drops in the cycle after the retire edge, unless another write to the same register is still pending.
- Throughput is one issue per cycle; the block applies no backpressure of its own.
- Priority order: reset_n > flush > stall > normal.
- Back-to-back writes to the same register:
  - Each write retires separately, in issue order.
  - The hazard stays high until the last one retires.
- wb_valid and wb_addr are registered-stage derived; only the stall/flush gating is combinational.

## Test plan
- Basic path, DEPTH=3: issue rd_select=1, rd_addr=8 at cycle 0 -> issue_dest=8; hazard for src_a=8 high in cycles 1-3; wb_valid=1 with wb_addr=8 in cycle 3; hazard low in cycle 4.
- Mode coverage: rd_select=0 with rt=5, 2, and 3 -> writebacks to 5 and 31, no writeback for mode 3. With rt=0 and mode 0 -> no writeback, no hazard on src 0.
- Same-register overlap: issue to register 9 in cycles 0, 1, 2 -> three wb_valid pulses to 9 in cycles 3-5; hazard for 9 held through cycle 5 and low in cycle 6; count never exceeds 3.
- Stall: issue to register 4, then stall for 2 cycles mid-flight -> writeback delayed by exactly 2 cycles; wb_valid low while stalled; issue_valid during stall is ignored.
- Flush: issue to 4, 6, 7, then flush with a concurrent issue to 10 -> no writebacks for 4, 6, 7 or 10; all hazards low and busy=0 the cycle after.
- Async reset: assert reset_n low mid-clock with 3 writes in flight -> all outputs 0 immediately, with no writeback after release.
